// File: rtl/cv32e41p_pkg.sv
// Shared types for the OBI arbiter: requester IDs, request payload struct, depth limit.
// No logic; imported by the arbiter and its ID FIFO.
// Backpressure: n/a.
package cv32e41p_pkg;

    typedef enum logic {
        OBI_PORT_DATA  = 1'b0,
        OBI_PORT_INSTR = 1'b1
    } obi_port_id_e;

    localparam int unsigned OBI_ARB_MAX_OUTSTANDING_LIMIT = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [5:0]  atop;
    } obi_req_t;

endpackage

// File: rtl/cv32e41p_obi_id_fifo.sv
// In-order FIFO of requester IDs, one entry per accepted-but-unanswered transaction.
// Latency: head visible combinationally, push/pop take effect at the next clk edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module cv32e41p_obi_id_fifo
    import cv32e41p_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  obi_port_id_e     push_id,
    input  logic             pop,
    output obi_port_id_e     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = obi_port_id_e'(mem[rd_ptr]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cv32e41p_obi_arbiter.sv
// Two-requester OBI arbiter (data port 0, instruction port 1) onto one transaction interface.
// Latency: 0 cycles on both the request path and the response path (pure combinational muxing).
// Backpressure: ready follows trans_ready_i; no issue while MAX_OUTSTANDING responses are pending.
module cv32e41p_obi_arbiter
    import cv32e41p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ARB_MODE        = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_valid_i,
    output logic        p0_ready_o,
    input  logic [31:0] p0_addr_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_wdata_i,
    input  logic [5:0]  p0_atop_i,
    output logic        p0_resp_valid_o,
    output logic [31:0] p0_resp_rdata_o,
    output logic        p0_resp_err_o,

    input  logic        p1_valid_i,
    output logic        p1_ready_o,
    input  logic [31:0] p1_addr_i,
    output logic        p1_resp_valid_o,
    output logic [31:0] p1_resp_rdata_o,
    output logic        p1_resp_err_o,

    output logic        trans_valid_o,
    input  logic        trans_ready_i,
    output logic [31:0] trans_addr_o,
    output logic        trans_we_o,
    output logic [3:0]  trans_be_o,
    output logic [31:0] trans_wdata_o,
    output logic [5:0]  trans_atop_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,

    output logic        busy_o
);

    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam bit          RR_MODE  = (ARB_MODE != 0);

    obi_port_id_e     grant;
    obi_port_id_e     last_grant;
    obi_port_id_e     head_id;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             can_issue;
    logic             accept;
    logic             resp_pop;
    obi_req_t         p0_req;
    obi_req_t         p1_req;
    obi_req_t         sel_req;

    // Gated only on the registered count so a same-cycle response never opens the door.
    assign can_issue = ~fifo_full;

    always_comb begin
        grant = OBI_PORT_DATA;
        if (p1_valid_i && !p0_valid_i) begin
            grant = OBI_PORT_INSTR;
        end else if (p1_valid_i && p0_valid_i && RR_MODE && (last_grant == OBI_PORT_DATA)) begin
            grant = OBI_PORT_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= OBI_PORT_INSTR;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

    assign p0_req = '{addr: p0_addr_i, we: p0_we_i, be: p0_be_i, wdata: p0_wdata_i, atop: p0_atop_i};
    assign p1_req = '{addr: p1_addr_i, we: 1'b0, be: 4'hF, wdata: '0, atop: '0};
    assign sel_req = (grant == OBI_PORT_INSTR) ? p1_req : p0_req;

    assign trans_valid_o = can_issue & (p0_valid_i | p1_valid_i);
    assign trans_addr_o  = sel_req.addr;
    assign trans_we_o    = sel_req.we;
    assign trans_be_o    = sel_req.be;
    assign trans_wdata_o = sel_req.wdata;
    assign trans_atop_o  = sel_req.atop;

    assign p0_ready_o = trans_ready_i & can_issue & (grant == OBI_PORT_DATA);
    assign p1_ready_o = trans_ready_i & can_issue & (grant == OBI_PORT_INSTR);
    assign accept     = trans_valid_o & trans_ready_i;

    cv32e41p_obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .push_id (grant),
        .pop     (resp_pop),
        .head    (head_id),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Responses with nothing outstanding are dropped rather than routed.
    assign resp_pop        = resp_valid_i & ~fifo_empty;
    assign p0_resp_valid_o = resp_pop & (head_id == OBI_PORT_DATA);
    assign p1_resp_valid_o = resp_pop & (head_id == OBI_PORT_INSTR);
    assign p0_resp_rdata_o = resp_rdata_i;
    assign p1_resp_rdata_o = resp_rdata_i;
    assign p0_resp_err_o   = resp_err_i;
    assign p1_resp_err_o   = resp_err_i;

    assign busy_o = (fifo_count != '0);

    cv32e41p_obi_arbiter_no_spurious_resp: assert property (
        @(posedge clk) disable iff (!rst_n) !(resp_valid_i && fifo_empty)
    );

endmodule

// File: tb/tb_cv32e41p_obi_arbiter.sv
// Bench for cv32e41p_obi_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each checked every cycle against a queue-based model of outstanding requester IDs.
module tb_cv32e41p_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_we, p1_valid, trans_ready, resp_valid, resp_err;
    logic [31:0] p0_addr, p0_wdata, p1_addr, resp_rdata;
    logic [3:0]  p0_be;
    logic [5:0]  p0_atop;

    logic        p0_ready[2], p1_ready[2], p0_resp_valid[2], p1_resp_valid[2];
    logic        p0_resp_err[2], p1_resp_err[2], trans_valid[2], trans_we[2], busy[2];
    logic [31:0] p0_resp_rdata[2], p1_resp_rdata[2], trans_addr[2], trans_wdata[2];
    logic [3:0]  trans_be[2];
    logic [5:0]  trans_atop[2];

    int errors = 0;
    int checks = 0;

    bit mq[2][$];
    bit lastg[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cv32e41p_obi_arbiter #(
            .MAX_OUTSTANDING (2),
            .ARB_MODE        ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .p0_valid_i      (p0_valid),
            .p0_ready_o      (p0_ready[g]),
            .p0_addr_i       (p0_addr),
            .p0_we_i         (p0_we),
            .p0_be_i         (p0_be),
            .p0_wdata_i      (p0_wdata),
            .p0_atop_i       (p0_atop),
            .p0_resp_valid_o (p0_resp_valid[g]),
            .p0_resp_rdata_o (p0_resp_rdata[g]),
            .p0_resp_err_o   (p0_resp_err[g]),
            .p1_valid_i      (p1_valid),
            .p1_ready_o      (p1_ready[g]),
            .p1_addr_i       (p1_addr),
            .p1_resp_valid_o (p1_resp_valid[g]),
            .p1_resp_rdata_o (p1_resp_rdata[g]),
            .p1_resp_err_o   (p1_resp_err[g]),
            .trans_valid_o   (trans_valid[g]),
            .trans_ready_i   (trans_ready),
            .trans_addr_o    (trans_addr[g]),
            .trans_we_o      (trans_we[g]),
            .trans_be_o      (trans_be[g]),
            .trans_wdata_o   (trans_wdata[g]),
            .trans_atop_o    (trans_atop[g]),
            .resp_valid_i    (resp_valid),
            .resp_rdata_i    (resp_rdata),
            .resp_err_i      (resp_err),
            .busy_o          (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        p0_valid = 0; p0_we = 0; p0_be = 0; p0_addr = 0; p0_wdata = 0; p0_atop = 0;
        p1_valid = 0; p1_addr = 0; trans_ready = 0;
        resp_valid = 0; resp_err = 0; resp_rdata = 0;
    endtask

    // Called just after a negedge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        bit acc[2];
        bit popd[2];
        bit gv[2];
        #1;
        for (int k = 0; k < 2; k++) begin
            bit rr, can, any, g, rv, hd;
            rr  = (k == 0);
            can = mq[k].size() < 2;
            any = p0_valid | p1_valid;
            if (p0_valid && p1_valid) g = rr ? ~lastg[k] : 1'b0;
            else                      g = p1_valid;
            rv = resp_valid && (mq[k].size() > 0);
            hd = rv ? mq[k][0] : 1'b0;

            check($sformatf("d%0d_tvalid", k), trans_valid[k], can & any);
            if (any) begin
                check($sformatf("d%0d_p0_rdy", k), p0_ready[k], trans_ready & can & ~g);
                check($sformatf("d%0d_p1_rdy", k), p1_ready[k], trans_ready & can & g);
            end
            if (can && any) begin
                check($sformatf("d%0d_addr", k), trans_addr[k], g ? p1_addr : p0_addr);
                check($sformatf("d%0d_we", k), trans_we[k], g ? 1'b0 : p0_we);
                check($sformatf("d%0d_be", k), trans_be[k], g ? 4'hF : p0_be);
                check($sformatf("d%0d_wdata", k), trans_wdata[k], g ? 32'h0 : p0_wdata);
                check($sformatf("d%0d_atop", k), trans_atop[k], g ? 6'h0 : p0_atop);
            end
            check($sformatf("d%0d_p0_rvld", k), p0_resp_valid[k], rv & ~hd);
            check($sformatf("d%0d_p1_rvld", k), p1_resp_valid[k], rv & hd);
            check($sformatf("d%0d_p0_rdata", k), p0_resp_rdata[k], resp_rdata);
            check($sformatf("d%0d_p1_rdata", k), p1_resp_rdata[k], resp_rdata);
            check($sformatf("d%0d_p0_err", k), p0_resp_err[k], resp_err);
            check($sformatf("d%0d_p1_err", k), p1_resp_err[k], resp_err);
            check($sformatf("d%0d_busy", k), busy[k], mq[k].size() != 0);
            acc[k]  = can & any & trans_ready;
            popd[k] = rv;
            gv[k]   = g;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                lastg[k] = 1'b1;
            end else begin
                if (popd[k]) void'(mq[k].pop_front());
                if (acc[k]) begin
                    mq[k].push_back(gv[k]);
                    lastg[k] = gv[k];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic drain();
        idle();
        resp_valid = 1;
        for (int n = 0; n < 8 && mq[0].size() > 0; n++) begin
            resp_rdata = $urandom;
            cycle();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            lastg[k] = 1'b1;
        end
        rst_n = 1;

        // Reset state with no requests, then a single instruction fetch and its response.
        cycle();
        p1_valid = 1; p1_addr = 32'h0000_0100; trans_ready = 1;
        #1;
        check("t1_be", trans_be[0], 4'hF);
        check("t1_we", trans_we[0], 0);
        cycle();
        idle();
        cycle();
        resp_valid = 1; resp_rdata = 32'hDEAD_BEEF;
        #1;
        check("t1_p1_rvld", p1_resp_valid[0], 1);
        check("t1_p0_rvld", p0_resp_valid[0], 0);
        cycle();

        // Both ports hammering with immediate responses: RR alternates, fixed stays on port 0.
        do_reset();
        p0_valid = 1; p1_valid = 1; trans_ready = 1;
        for (int i = 0; i < 8; i++) begin
            p0_addr = $urandom; p0_wdata = $urandom; p0_we = 1'($urandom);
            p0_be = 4'($urandom); p0_atop = 6'($urandom); p1_addr = $urandom;
            resp_valid = (i > 0); resp_rdata = $urandom;
            #1;
            check("alt_p1_rdy", p1_ready[0], 32'(i % 2));
            check("fp_p1_rdy", p1_ready[1], 0);
            cycle();
        end
        drain();

        // Outstanding limit: third write stalls, and a same-cycle response does not release it.
        do_reset();
        p0_valid = 1; p0_we = 1; p0_be = 4'hF; p0_wdata = 32'h1234_5678; trans_ready = 1;
        cycle();
        cycle();
        #1;
        check("full_p0_rdy", p0_ready[0], 0);
        check("full_tvalid", trans_valid[0], 0);
        cycle();
        resp_valid = 1;
        #1;
        check("pop_same_cyc_rdy", p0_ready[0], 0);
        cycle();
        resp_valid = 0;
        #1;
        check("after_pop_rdy", p0_ready[0], 1);
        cycle();
        drain();

        // Error reported on the second of two outstanding (instr then data).
        do_reset();
        p1_valid = 1; p1_addr = 32'h40; trans_ready = 1;
        cycle();
        p1_valid = 0; p0_valid = 1; p0_addr = 32'h80;
        cycle();
        idle();
        resp_valid = 1;
        cycle();
        resp_err = 1; resp_rdata = 32'hBAD0_0BAD;
        #1;
        check("err_p0_rvld", p0_resp_valid[0], 1);
        check("err_p0_err", p0_resp_err[0], 1);
        cycle();
        idle();
        #1;
        check("err_busy", busy[0], 0);
        cycle();

        // Reset with two outstanding: a late response must be dropped.
        do_reset();
        p0_valid = 1; trans_ready = 1;
        cycle();
        cycle();
        idle();
        rst_n = 0;
        cycle();
        resp_valid = 1; resp_rdata = 32'hCAFE_F00D;
        #1;
        check("rst_p0_rvld", p0_resp_valid[0], 0);
        check("rst_p1_rvld", p1_resp_valid[0], 0);
        check("rst_busy", busy[0], 0);
        cycle();
        resp_valid = 0;
        rst_n = 1;
        cycle();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            p0_valid = 1'($urandom); p1_valid = 1'($urandom);
            trans_ready = ($urandom_range(0, 3) != 0);
            p0_addr = $urandom; p0_wdata = $urandom; p0_we = 1'($urandom);
            p0_be = 4'($urandom); p0_atop = 6'($urandom); p1_addr = $urandom;
            resp_valid = (mq[0].size() > 0) && ($urandom_range(0, 1) == 1);
            resp_rdata = $urandom; resp_err = 1'($urandom);
            cycle();
        end
        drain();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
